// File: rtl/opc6_bus_responder.sv
// Target side of the opc6 CPU bus: word RAM, wait-state clock enable and a small
// IO page with a character-output FIFO and a periodic interrupt timer.
module opc6_bus_responder #(
   parameter int MEM_AW      = 12,
   parameter int WAIT_STATES = 1,
   parameter int TXF_AW      = 3,
   parameter int TIMER_W     = 16
) (
   input  logic        clk,
   input  logic        reset_b,
   input  logic [15:0] address,
   input  logic [15:0] cpu_dout,
   output logic [15:0] cpu_din,
   input  logic        rnw,
   input  logic        vpa,
   input  logic        vda,
   input  logic        vio,
   output logic        clken,
   output logic [1:0]  int_b,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int WCW       = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);
   localparam int MEM_DEPTH = 1 << MEM_AW;
   localparam int TXF_DEPTH = 1 << TXF_AW;
   localparam int CW        = TXF_AW + 1;

   localparam logic [15:0] ADDR_TXD    = 16'hFE08;
   localparam logic [15:0] ADDR_STAT   = 16'hFE09;
   localparam logic [15:0] ADDR_RELOAD = 16'hFE0A;
   localparam logic [15:0] ADDR_CTRL   = 16'hFE0B;

   logic               mreq;
   logic               req;
   logic               tx_stall;
   logic               complete;
   logic [WCW-1:0]     wcnt;

   logic [15:0]        mem [0:MEM_DEPTH-1];
   logic               ram_we;

   logic [7:0]         fifo_mem [0:TXF_DEPTH-1];
   logic [TXF_AW-1:0]  wr_ptr;
   logic [TXF_AW-1:0]  rd_ptr;
   logic [CW-1:0]      fifo_count;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_push;
   logic               fifo_pop;

   logic               io_wr;
   logic               reload_wr;
   logic               ctrl_wr;
   logic [15:0]        io_rdata;

   logic [TIMER_W-1:0] reload;
   logic [TIMER_W-1:0] count;
   logic               enable;
   logic               pending;
   logic               expire;

   assign mreq       = vpa | vda;
   assign req        = mreq | vio;
   assign fifo_full  = (fifo_count == CW'(TXF_DEPTH));
   assign fifo_empty = (fifo_count == '0);
   assign tx_stall   = vio & ~rnw & (address == ADDR_TXD) & fifo_full;

   // The reset term lets an in-flight cycle release the CPU immediately while
   // also keeping 'complete' false so nothing is written during reset.
   assign clken    = ~reset_b | ~req | ((wcnt == WCW'(WAIT_STATES)) & ~tx_stall);
   assign complete = reset_b & req & clken;

   assign ram_we    = complete & mreq & ~rnw;
   assign io_wr     = complete & vio & ~mreq & ~rnw;
   assign fifo_push = io_wr & (address == ADDR_TXD);
   assign reload_wr = io_wr & (address == ADDR_RELOAD);
   assign ctrl_wr   = io_wr & (address == ADDR_CTRL);
   assign fifo_pop  = ~fifo_empty & tx_ready;

   assign tx_valid = ~fifo_empty;
   assign tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

   assign expire = enable & (count == '0);
   assign int_b  = {1'b1, ~(pending & enable)};

   // Saturates at WAIT_STATES so a FIFO-stalled push stays ready to complete.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         wcnt <= '0;
      end else if (clken) begin
         wcnt <= '0;
      end else if (req && (wcnt != WCW'(WAIT_STATES))) begin
         wcnt <= wcnt + WCW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[address[MEM_AW-1:0]] <= cpu_dout;
      end
   end

   always_comb begin
      io_rdata = '0;
      if (vio) begin
         case (address)
            ADDR_STAT:   io_rdata[1:0] = {fifo_full, fifo_empty};
            ADDR_RELOAD: io_rdata[TIMER_W-1:0] = reload;
            ADDR_CTRL:   io_rdata[1:0] = {pending, enable};
            default:     io_rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         cpu_din <= '0;
      end else begin
         cpu_din <= mreq ? mem[address[MEM_AW-1:0]] : io_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_push) begin
         fifo_mem[wr_ptr] <= cpu_dout[7:0];
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (fifo_push) begin
            wr_ptr <= wr_ptr + TXF_AW'(1);
         end
         if (fifo_pop) begin
            rd_ptr <= rd_ptr + TXF_AW'(1);
         end
         fifo_count <= fifo_count + CW'(fifo_push) - CW'(fifo_pop);
      end
   end

   // A reload write takes precedence over the running count; an expiry beats
   // a software clear of pending on the same edge.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         reload  <= '0;
         count   <= '0;
         enable  <= 1'b0;
         pending <= 1'b0;
      end else begin
         if (reload_wr) begin
            reload <= cpu_dout[TIMER_W-1:0];
            count  <= cpu_dout[TIMER_W-1:0];
         end else if (enable) begin
            count <= expire ? reload : count - TIMER_W'(1);
         end
         if (ctrl_wr) begin
            enable <= cpu_dout[0];
         end
         if (expire) begin
            pending <= 1'b1;
         end else if (ctrl_wr && cpu_dout[1]) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_opc6_bus_responder.sv
// Directed bench for opc6_bus_responder: one instance with one wait state and one
// with three, sharing the same bus stimulus.
module tb_opc6_bus_responder;

   logic        clk = 1'b0;
   logic        reset_b = 1'b0;
   logic [15:0] address = '0;
   logic [15:0] cpu_dout = '0;
   logic        rnw = 1'b1;
   logic        vpa = 1'b0;
   logic        vda = 1'b0;
   logic        vio = 1'b0;
   logic        tx_ready = 1'b0;

   logic [15:0] cpu_din0, cpu_din1;
   logic        clken0, clken1;
   logic [1:0]  int_b0, int_b1;
   logic [7:0]  tx_data0, tx_data1;
   logic        tx_valid0, tx_valid1;

   int vectors = 0;
   int miscompares = 0;

   logic [15:0] q;
   int          w;
   int          n;

   opc6_bus_responder #(.WAIT_STATES(1)) u0 (
      .clk(clk), .reset_b(reset_b), .address(address), .cpu_dout(cpu_dout),
      .cpu_din(cpu_din0), .rnw(rnw), .vpa(vpa), .vda(vda), .vio(vio),
      .clken(clken0), .int_b(int_b0), .tx_data(tx_data0), .tx_valid(tx_valid0),
      .tx_ready(tx_ready)
   );

   opc6_bus_responder #(.WAIT_STATES(3)) u1 (
      .clk(clk), .reset_b(reset_b), .address(address), .cpu_dout(cpu_dout),
      .cpu_din(cpu_din1), .rnw(rnw), .vpa(vpa), .vda(vda), .vio(vio),
      .clken(clken1), .int_b(int_b1), .tx_data(tx_data1), .tx_valid(tx_valid1),
      .tx_ready(tx_ready)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // kind: 0=vda, 1=vpa, 2=vio, 3=vio+vda. Returns read data and clken-low cycles.
   task automatic apply_stimulus(input int sel, input logic [15:0] a, input logic [15:0] d,
                                 input logic rd, input int kind,
                                 output logic [15:0] rdata, output int waits);
      @(negedge clk);
      address  = a;
      cpu_dout = d;
      rnw      = rd;
      vda      = (kind == 0) || (kind == 3);
      vpa      = (kind == 1);
      vio      = (kind >= 2);
      waits    = 0;
      #1;
      while ((((sel == 1) ? clken1 : clken0) !== 1'b1) && (waits < 50)) begin
         waits++;
         @(negedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      rdata = (sel == 1) ? cpu_din1 : cpu_din0;
      vda = 1'b0;
      vpa = 1'b0;
      vio = 1'b0;
      rnw = 1'b1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clk);
      check_output("rst_clken", {15'b0, clken0}, 16'h0001);
      check_output("rst_cpu_din", cpu_din0, 16'h0000);
      check_output("rst_int_b", {14'b0, int_b0}, 16'h0003);
      check_output("rst_tx_valid", {15'b0, tx_valid0}, 16'h0000);
      check_output("rst_tx_data", {8'b0, tx_data0}, 16'h0000);
      reset_b = 1'b1;

      apply_stimulus(0, 16'h0010, 16'h1234, 1'b0, 0, q, w);
      check_output("wr_waits_ws1", w[15:0], 16'd1);
      apply_stimulus(0, 16'h0010, 16'h0000, 1'b1, 0, q, w);
      check_output("rd_waits_ws1", w[15:0], 16'd1);
      check_output("rd_0010", q, 16'h1234);

      apply_stimulus(0, 16'h1010, 16'hBEEF, 1'b0, 0, q, w);
      apply_stimulus(0, 16'h0010, 16'h0000, 1'b1, 0, q, w);
      check_output("rd_alias", q, 16'hBEEF);

      apply_stimulus(1, 16'h0100, 16'h7777, 1'b0, 0, q, w);
      check_output("wr_waits_ws3", w[15:0], 16'd3);
      apply_stimulus(1, 16'h0100, 16'h0000, 1'b1, 1, q, w);
      check_output("rd_waits_ws3", w[15:0], 16'd3);
      check_output("rd_vpa_ws3", q, 16'h7777);

      apply_stimulus(0, 16'h0E09, 16'h4242, 1'b0, 0, q, w);
      apply_stimulus(0, 16'hFE09, 16'h0000, 1'b1, 3, q, w);
      check_output("mreq_priority", q, 16'h4242);
      apply_stimulus(0, 16'hFE0F, 16'h0000, 1'b1, 2, q, w);
      check_output("io_unmapped", q, 16'h0000);

      for (int i = 0; i < 8; i++) begin
         apply_stimulus(0, 16'hFE08, 16'h0041 + 16'(i), 1'b0, 2, q, w);
         check_output("push_waits", w[15:0], 16'd1);
      end
      apply_stimulus(0, 16'hFE09, 16'h0000, 1'b1, 2, q, w);
      check_output("stat_full", q, 16'h0002);
      apply_stimulus(0, 16'hFE08, 16'h0000, 1'b1, 2, q, w);
      check_output("txd_read_zero", q, 16'h0000);
      check_output("head_A", {8'b0, tx_data0}, 16'h0041);

      fork
         apply_stimulus(0, 16'hFE08, 16'h0049, 1'b0, 2, q, w);
         begin
            repeat (3) @(negedge clk);
            #2;
            check_output("stall_clken", {15'b0, clken0}, 16'h0000);
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
         end
      join
      check_output("stall_waits", w[15:0], 16'd3);

      for (int i = 1; i < 9; i++) begin
         @(negedge clk);
         check_output("drain_order", {8'b0, tx_data0}, 16'h0041 + 16'(i));
         tx_ready = 1'b1;
      end
      @(negedge clk);
      tx_ready = 1'b0;
      check_output("drain_empty", {15'b0, tx_valid0}, 16'h0000);

      for (int i = 0; i < 3; i++) begin
         apply_stimulus(0, 16'hFE08, 16'h0061 + 16'(i), 1'b0, 2, q, w);
      end
      @(negedge clk);
      address  = 16'hFE08;
      cpu_dout = 16'h0064;
      rnw      = 1'b0;
      vio      = 1'b1;
      #1;
      check_output("sim_wait", {15'b0, clken0}, 16'h0000);
      @(negedge clk);
      #1;
      check_output("sim_ready", {15'b0, clken0}, 16'h0001);
      tx_ready = 1'b1;
      @(posedge clk);
      #1;
      vio = 1'b0;
      rnw = 1'b1;
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_output("sim_order", {7'b0, tx_valid0, tx_data0}, 16'h0162 + 16'(i));
         tx_ready = 1'b1;
      end
      @(negedge clk);
      tx_ready = 1'b0;
      check_output("sim_empty", {15'b0, tx_valid0}, 16'h0000);

      apply_stimulus(0, 16'hFE0A, 16'h0004, 1'b0, 2, q, w);
      apply_stimulus(0, 16'hFE0A, 16'h0000, 1'b1, 2, q, w);
      check_output("reload_read", q, 16'h0004);
      apply_stimulus(0, 16'hFE0B, 16'h0001, 1'b0, 2, q, w);
      check_output("tmr_enable", {15'b0, int_b0[0]}, 16'h0001);
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         #1;
         check_output("tmr_count", {15'b0, int_b0[0]}, (k == 5) ? 16'h0000 : 16'h0001);
      end
      apply_stimulus(0, 16'hFE0B, 16'h0003, 1'b0, 2, q, w);
      check_output("tmr_clear", {15'b0, int_b0[0]}, 16'h0001);
      n = 0;
      while ((int_b0[0] === 1'b1) && (n < 20)) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_output("tmr_reexpire", n[15:0], 16'd3);

      apply_stimulus(0, 16'hFE0A, 16'h0000, 1'b0, 2, q, w);
      apply_stimulus(0, 16'hFE0B, 16'h0003, 1'b0, 2, q, w);
      check_output("clear_vs_set", {15'b0, int_b0[0]}, 16'h0000);
      apply_stimulus(0, 16'hFE0B, 16'h0000, 1'b1, 2, q, w);
      check_output("ctrl_read", q, 16'h0003);
      apply_stimulus(0, 16'hFE0B, 16'h0002, 1'b0, 2, q, w);
      check_output("int_masked", {14'b0, int_b0}, 16'h0003);
      apply_stimulus(0, 16'hFE0B, 16'h0000, 1'b1, 2, q, w);
      check_output("ctrl_disabled", q, 16'h0002);

      apply_stimulus(0, 16'h0020, 16'h5A5A, 1'b0, 0, q, w);
      apply_stimulus(0, 16'hFE08, 16'h005A, 1'b0, 2, q, w);
      check_output("pre_rst_valid", {15'b0, tx_valid0}, 16'h0001);
      apply_stimulus(0, 16'hFE0B, 16'h0001, 1'b0, 2, q, w);
      check_output("pre_rst_int", {14'b0, int_b0}, 16'h0002);
      @(negedge clk);
      address  = 16'h0020;
      cpu_dout = 16'hDEAD;
      rnw      = 1'b0;
      vda      = 1'b1;
      #1;
      check_output("mid_wait", {15'b0, clken0}, 16'h0000);
      #1;
      reset_b = 1'b0;
      #1;
      check_output("arst_clken", {15'b0, clken0}, 16'h0001);
      check_output("arst_int_b", {14'b0, int_b0}, 16'h0003);
      check_output("arst_fifo", {15'b0, tx_valid0}, 16'h0000);
      check_output("arst_cpu_din", cpu_din0, 16'h0000);
      @(posedge clk);
      @(negedge clk);
      vda = 1'b0;
      rnw = 1'b1;
      reset_b = 1'b1;
      apply_stimulus(0, 16'h0020, 16'h0000, 1'b1, 0, q, w);
      check_output("write_dropped", q, 16'h5A5A);
      apply_stimulus(0, 16'hFE09, 16'h0000, 1'b1, 2, q, w);
      check_output("post_rst_stat", q, 16'h0001);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
